// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer.
//   Fetches a word from imem over req/ack into the IR, hands the opcode to the
//   external combinational control unit, then steps READ/EXEC/WB, turning the
//   control unit's enables into one-cycle strobes. Tracks pc, retired count,
//   and a sticky fault (fetch timeout or reserved instruction type).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   run                    1 = keep fetching, 0 = stop after current instruction
//   imem_req/addr/ack/data instruction fetch handshake
//   opcode, ir             IR opcode field and full IR to the control unit
//   inst_type, cu_*        control-unit decode results for the current IR
//   rf_rd_a/b, alu_go, rf_wr  one-cycle strobes in READ / EXEC / WB
//   pc, retire, retire_count, busy, fault  status
module exec_sequencer #(
  parameter int PC_WIDTH   = 8,
  parameter int INST_WIDTH = 24,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [INST_WIDTH-1:0] imem_data,
  output logic [5:0]            opcode,
  output logic [INST_WIDTH-1:0] ir,
  input  logic [1:0]            inst_type,
  input  logic                  cu_read_a,
  input  logic                  cu_read_b,
  input  logic                  cu_write,
  input  logic                  cu_alu_en,
  output logic                  rf_rd_a,
  output logic                  rf_rd_b,
  output logic                  alu_go,
  output logic                  rf_wr,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  retire,
  output logic [CNT_WIDTH-1:0]  retire_count,
  output logic                  busy,
  output logic                  fault
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_READ, S_EXEC, S_WB, S_FAULT
  } state_t;

  typedef struct packed {
    logic rd_a;
    logic rd_b;
    logic alu;
    logic wr;
  } cu_en_t;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [INST_WIDTH-1:0] ir_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [TW-1:0]         tcnt;
  cu_en_t                en_q;
  logic                  tmo_hit;
  logic                  nop_dec;

  // This is the cycle the counter would reach TIMEOUT; an ack here still wins.
  assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));
  assign nop_dec = (state == S_DECODE) && (inst_type == 2'b00);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack)     state_nxt = S_DECODE;
                else if (tmo_hit) state_nxt = S_FAULT;
      S_DECODE: case (inst_type)
                  2'b00:   state_nxt = run ? S_FETCH : S_IDLE;
                  2'b11:   state_nxt = S_FAULT;
                  default: state_nxt = S_READ;
                endcase
      S_READ:   state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = run ? S_FETCH : S_IDLE;
      S_FAULT:  state_nxt = S_FAULT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= '0;
      ir_q  <= '0;
      cnt_q <= '0;
      tcnt  <= '0;
      en_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        if (imem_ack) begin
          ir_q <= imem_data;
          pc_q <= pc_q + PC_WIDTH'(1);
          tcnt <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
      // Capture the control-unit enables once, so later strobes come from
      // registered state rather than the live decode.
      if (state == S_DECODE)
        en_q <= '{rd_a: cu_read_a, rd_b: cu_read_b, alu: cu_alu_en, wr: cu_write};
      if (retire)
        cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign imem_req     = (state == S_FETCH);
  assign imem_addr    = pc_q;
  assign ir           = ir_q;
  assign opcode       = ir_q[INST_WIDTH-1 -: 6];
  assign pc           = pc_q;
  assign rf_rd_a      = (state == S_READ) && en_q.rd_a;
  assign rf_rd_b      = (state == S_READ) && en_q.rd_b;
  assign alu_go       = (state == S_EXEC) && en_q.alu;
  assign rf_wr        = (state == S_WB)   && en_q.wr;
  assign retire       = (state == S_WB) || nop_dec;
  assign retire_count = cnt_q;
  assign busy         = (state != S_IDLE);
  assign fault        = (state == S_FAULT);

endmodule

// File: tb/tb_exec_sequencer.sv
module tb_exec_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, pc;
  logic [23:0] imem_data, ir;
  logic [5:0]  opcode;
  logic [1:0]  inst_type;
  logic        cu_read_a, cu_read_b, cu_write, cu_alu_en;
  logic        rf_rd_a, rf_rd_b, alu_go, rf_wr, retire, busy, fault;
  logic [15:0] retire_count;

  exec_sequencer #(.PC_WIDTH(8), .INST_WIDTH(24), .TIMEOUT(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .opcode(opcode), .ir(ir), .inst_type(inst_type),
    .cu_read_a(cu_read_a), .cu_read_b(cu_read_b), .cu_write(cu_write), .cu_alu_en(cu_alu_en),
    .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b), .alu_go(alu_go), .rf_wr(rf_wr),
    .pc(pc), .retire(retire), .retire_count(retire_count), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] NOP_W  = {6'd0,  18'h2A5A5};
  localparam logic [23:0] ADD_W  = {6'd1,  18'h00C03};
  localparam logic [23:0] LDIM_W = {6'd2,  18'h30ABC};
  localparam logic [23:0] RSV_W  = {6'h3F, 18'h12345};

  // Control-unit model. NOP and reserved still drive enables high so any
  // strobe leaking outside its state shows up.
  always_comb begin
    inst_type = 2'b00;
    cu_read_a = 1'b1; cu_read_b = 1'b1; cu_write = 1'b1; cu_alu_en = 1'b1;
    case (opcode)
      6'd1:    inst_type = 2'b01;
      6'd2:    begin inst_type = 2'b10; cu_read_a = 1'b0; cu_read_b = 1'b0; end
      6'h3F:   inst_type = 2'b11;
      default: inst_type = 2'b00;
    endcase
  end

  // Memory model: ack on the ack_at-th consecutive FETCH cycle (0 = never).
  logic [23:0] mem [256];
  int          ack_at = 1;
  logic        force_ack = 1'b0;
  int          req_cnt = 0;
  assign imem_ack  = !rst && (force_ack || (imem_req && ack_at != 0 && req_cnt == ack_at - 1));
  assign imem_data = mem[imem_addr];
  always @(posedge clk) req_cnt <= (rst || !imem_req) ? 0 : req_cnt + 1;

  typedef struct packed {
    logic [23:0] ir;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  int   vec = 0;
  int   err = 0;

  function automatic exp_t mk(logic [23:0] w, logic [7:0] p, logic [15:0] c);
    exp_t e;
    e.ir = w; e.pc = p; e.cnt = c;
    return e;
  endfunction

  function automatic logic [6:0] obs();
    return {imem_req, rf_rd_a, rf_rd_b, alu_go, rf_wr, retire, busy};
  endfunction

  // Advance one cycle; retire events are popped off the scoreboard here.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (!rst && retire) begin
      vec++;
      if (exp_q.size() == 0) begin
        err++;
        $display("FAIL sb_retire: unexpected retire ir=%h pc=%h", ir, pc);
      end else begin
        e = exp_q.pop_front();
        if ({ir, pc, retire_count} !== e) begin
          err++;
          $display("FAIL sb_retire: got ir=%h pc=%h cnt=%0d want ir=%h pc=%h cnt=%0d",
                   ir, pc, retire_count, e.ir, e.pc, e.cnt);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; force_ack = 1'b0; ack_at = 1;
    step(); step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic sb_drained(string name);
    vec++;
    if (exp_q.size() != 0) begin
      err++;
      $display("FAIL %s_drain: %0d retires outstanding, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({obs(), rf_rd_a, fault, pc, ir, retire_count} !== '0) begin
      err++;
      $display("FAIL reset_state: obs=%b fault=%b pc=%h ir=%h cnt=%0d want all 0",
               obs(), fault, pc, ir, retire_count);
    end
  endtask

  task automatic run_table(string name, logic [6:0] tbl[6], int drop_at);
    for (int c = 1; c <= 6; c++) begin
      step();
      vec++;
      if (obs() !== tbl[c-1]) begin
        err++;
        $display("FAIL %s_c%0d: obs=%b want %b", name, c, obs(), tbl[c-1]);
      end
      if (c == 1) begin
        vec++;
        if (imem_addr !== 8'd0) begin
          err++;
          $display("FAIL %s_addr: imem_addr=%h want 00", name, imem_addr);
        end
      end
      if (c == drop_at) run = 1'b0;
    end
  endtask

  task automatic test_add();
    logic [6:0] tbl[6] = '{7'b1000001, 7'b0000001, 7'b0110001, 7'b0001001, 7'b0000111, 7'b0000000};
    do_reset();
    mem[0] = ADD_W;
    exp_q.push_back(mk(ADD_W, 8'd1, 16'd0));
    run = 1'b1;
    run_table("add", tbl, 4);  // run dropped in EXEC: WB must still retire
    vec++;
    if (pc !== 8'd1 || retire_count !== 16'd1) begin
      err++;
      $display("FAIL add_final: pc=%h cnt=%0d want pc=01 cnt=1", pc, retire_count);
    end
    sb_drained("add");
  endtask

  task automatic test_ldim();
    logic [6:0] tbl[6] = '{7'b1000001, 7'b0000001, 7'b0000001, 7'b0001001, 7'b0000111, 7'b0000000};
    do_reset();
    mem[0] = LDIM_W;
    exp_q.push_back(mk(LDIM_W, 8'd1, 16'd0));
    run = 1'b1;
    run_table("ldim", tbl, 1);
    sb_drained("ldim");
  endtask

  task automatic test_nops();
    logic [6:0] want;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem[i] = NOP_W;
      exp_q.push_back(mk(NOP_W, 8'(i + 1), 16'(i)));
    end
    run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      want = (c == 7) ? 7'b0000000 : ((c % 2 == 1) ? 7'b1000001 : 7'b0000011);
      vec++;
      if (obs() !== want) begin
        err++;
        $display("FAIL nops_c%0d: obs=%b want %b", c, obs(), want);
      end
      if (c == 5) run = 1'b0;
    end
    vec++;
    if (pc !== 8'd3 || retire_count !== 16'd3) begin
      err++;
      $display("FAIL nops_final: pc=%h cnt=%0d want pc=03 cnt=3", pc, retire_count);
    end
    sb_drained("nops");
  endtask

  task automatic test_back_to_back();
    int  rt[$];
    int  want[3] = '{5, 10, 12};
    bit  done = 0;
    do_reset();
    mem[0] = ADD_W; mem[1] = LDIM_W; mem[2] = NOP_W;
    exp_q.push_back(mk(ADD_W,  8'd1, 16'd0));
    exp_q.push_back(mk(LDIM_W, 8'd2, 16'd1));
    exp_q.push_back(mk(NOP_W,  8'd3, 16'd2));
    run = 1'b1;
    for (int i = 1; i <= 40 && !done; i++) begin
      step();
      if (retire) rt.push_back(i);
      if (imem_req && imem_addr == 8'd2) run = 1'b0;
      if (!busy) done = 1;
    end
    vec++;
    if (!done) begin
      err++;
      $display("FAIL b2b_idle: busy still %b after 40 cycles, want 0", busy);
    end
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (k >= rt.size() || rt[k] !== want[k]) begin
        err++;
        $display("FAIL b2b_retire%0d: cycle=%0d want %0d", k, (k < rt.size()) ? rt[k] : -1, want[k]);
      end
    end
    sb_drained("b2b");
  endtask

  task automatic test_timeout();
    do_reset();
    mem[0] = ADD_W;
    ack_at = 0;
    run = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      vec++;
      if (imem_req !== 1'b1 || fault !== 1'b0) begin
        err++;
        $display("FAIL tmo_wait_c%0d: req=%b fault=%b want req=1 fault=0", c, imem_req, fault);
      end
    end
    step();
    vec++;
    if (fault !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b1) begin
      err++;
      $display("FAIL tmo_fault: fault=%b req=%b busy=%b want 1 0 1", fault, imem_req, busy);
    end
    force_ack = 1'b1;
    repeat (4) step();
    force_ack = 1'b0;
    vec++;
    if (fault !== 1'b1 || pc !== 8'd0 || ir !== 24'd0 || imem_req !== 1'b0) begin
      err++;
      $display("FAIL tmo_sticky: fault=%b pc=%h ir=%h req=%b want 1 00 000000 0", fault, pc, ir, imem_req);
    end
    do_reset();
    vec++;
    if (fault !== 1'b0 || busy !== 1'b0 || pc !== 8'd0) begin
      err++;
      $display("FAIL tmo_reset: fault=%b busy=%b pc=%h want 0 0 00", fault, busy, pc);
    end
    // Ack on the last permitted cycle completes the fetch.
    mem[0] = NOP_W;
    exp_q.push_back(mk(NOP_W, 8'd1, 16'd0));
    ack_at = 16;
    run = 1'b1;
    repeat (16) step();
    vec++;
    if (fault !== 1'b0 || imem_req !== 1'b1 || imem_ack !== 1'b1) begin
      err++;
      $display("FAIL tmo_last_ack: fault=%b req=%b ack=%b want 0 1 1", fault, imem_req, imem_ack);
    end
    run = 1'b0;
    step();
    vec++;
    if (fault !== 1'b0 || retire !== 1'b1 || ir !== NOP_W) begin
      err++;
      $display("FAIL tmo_decode: fault=%b retire=%b ir=%h want 0 1 %h", fault, retire, ir, NOP_W);
    end
    step();
    vec++;
    if (busy !== 1'b0) begin
      err++;
      $display("FAIL tmo_idle: busy=%b want 0", busy);
    end
    sb_drained("tmo");
  endtask

  task automatic test_pc_wrap();
    bit hit = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = {6'd0, 18'(i)};
      exp_q.push_back(mk({6'd0, 18'(i)}, 8'(i + 1), 16'(i)));
    end
    run = 1'b1;
    for (int i = 0; i < 600 && !hit; i++) begin
      step();
      if (imem_req && imem_addr == 8'hFF) begin run = 1'b0; hit = 1; end
    end
    vec++;
    if (!hit) begin
      err++;
      $display("FAIL wrap_reach: fetch of addr ff not seen in 600 cycles");
    end
    step(); step();
    vec++;
    if (pc !== 8'd0 || retire_count !== 16'd256 || busy !== 1'b0) begin
      err++;
      $display("FAIL wrap_final: pc=%h cnt=%0d busy=%b want 00 256 0", pc, retire_count, busy);
    end
    sb_drained("wrap");
  endtask

  task automatic test_rst_mid();
    bit wr_seen = 0;
    do_reset();
    mem[0] = ADD_W;
    run = 1'b1;
    repeat (4) step();
    vec++;
    if (alu_go !== 1'b1) begin
      err++;
      $display("FAIL rstmid_exec: alu_go=%b want 1", alu_go);
    end
    rst = 1'b1;
    step();
    vec++;
    if (obs() !== 7'b0 || pc !== 8'd0 || ir !== 24'd0 || retire_count !== 16'd0) begin
      err++;
      $display("FAIL rstmid_idle: obs=%b pc=%h ir=%h cnt=%0d want all 0", obs(), pc, ir, retire_count);
    end
    rst = 1'b0; run = 1'b0;
    repeat (3) begin step(); if (rf_wr) wr_seen = 1; end
    vec++;
    if (wr_seen || retire_count !== 16'd0) begin
      err++;
      $display("FAIL rstmid_after: rf_wr_seen=%b cnt=%0d want 0 0", wr_seen, retire_count);
    end
  endtask

  task automatic test_reserved();
    do_reset();
    mem[0] = RSV_W;
    run = 1'b1;
    step(); step();
    vec++;
    if (obs() !== 7'b0000001) begin
      err++;
      $display("FAIL rsv_decode: obs=%b want 0000001", obs());
    end
    repeat (4) step();
    vec++;
    if (fault !== 1'b1 || busy !== 1'b1 || imem_req !== 1'b0 || pc !== 8'd1 ||
        ir !== RSV_W || retire_count !== 16'd0) begin
      err++;
      $display("FAIL rsv_fault: fault=%b busy=%b req=%b pc=%h ir=%h cnt=%0d want 1 1 0 01 %h 0",
               fault, busy, imem_req, pc, ir, retire_count, RSV_W);
    end
    do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = NOP_W;
    test_reset();
    test_add();
    test_ldim();
    test_nops();
    test_back_to_back();
    test_timeout();
    test_pc_wrap();
    test_rst_mid();
    test_reserved();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
